// File: rtl/ptn_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ptn_sequencer_pkg
// Purpose  : Shared defaults and state encoding for the pattern sequencer.
// Revision : 1.0  initial release
// ============================================================================
package ptn_sequencer_pkg;

    localparam int PTN_NUM_DEF        = 8;
    localparam int PTN_W_DEF          = 4;
    localparam int FRAMES_PER_PTN_DEF = 60;
    localparam int DEBOUNCE_CYC_DEF   = 250000;
    localparam int FRAME_CNT_W        = 10;

    typedef enum logic {
        S_MANUAL = 1'b0,
        S_AUTO   = 1'b1
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/ptn_sequencer_btn_sync.sv
`default_nettype none
// ============================================================================
// Module   : ptn_btn_sync
// Purpose  : Push-button synchronizer, optional debouncer (PTN_SEQ_DEBOUNCE_EN)
//            and rising-edge detect producing a one-cycle btn_evt.
// Revision : 1.0  initial release
// ============================================================================
module ptn_btn_sync
    import ptn_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic PCK,
    input  logic RST,
    input  logic BTN_NEXT,
    output logic btn_evt
);

    generate
        if (DEBOUNCE_CYC < 1) begin : g_bad_param
            $error("ptn_btn_sync: DEBOUNCE_CYC must be at least 1");
        end
    endgenerate

    logic sync1_q;
    logic sync2_q;
    logic lvl_prev_q;
    logic btn_lvl;

    always_ff @(posedge PCK or posedge RST) begin
        if (RST) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            lvl_prev_q <= 1'b0;
        end else begin
            sync1_q    <= BTN_NEXT;
            sync2_q    <= sync1_q;
            lvl_prev_q <= btn_lvl;
        end
    end

`ifdef PTN_SEQ_DEBOUNCE_EN
    localparam int                C_DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [C_DB_W-1:0] C_DB_LAST = C_DB_W'(DEBOUNCE_CYC - 1);

    logic [C_DB_W-1:0] db_cnt_q;
    logic [C_DB_W-1:0] db_cnt_d;
    logic              db_lvl_q;
    logic              db_lvl_d;

    // Count consecutive cycles in which the input disagrees with the accepted level.
    always_comb begin
        db_cnt_d = '0;
        db_lvl_d = db_lvl_q;
        if (sync2_q != db_lvl_q) begin
            if (db_cnt_q == C_DB_LAST) begin
                db_lvl_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + C_DB_W'(1);
            end
        end
    end

    always_ff @(posedge PCK or posedge RST) begin
        if (RST) begin
            db_cnt_q <= '0;
            db_lvl_q <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            db_lvl_q <= db_lvl_d;
        end
    end

    assign btn_lvl = db_lvl_q;
`else
    assign btn_lvl = sync2_q;
`endif

    assign btn_evt = btn_lvl & ~lvl_prev_q;

endmodule
`default_nettype wire

// File: rtl/ptn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ptn_sequencer
// Purpose  : Frame-synchronous test-pattern scheduler (auto / manual advance).
//            Optional button debouncer enabled by PTN_SEQ_DEBOUNCE_EN.
// Revision : 1.0  initial release
// ============================================================================
module ptn_sequencer
    import ptn_sequencer_pkg::*;
#(
    parameter int PTN_NUM        = PTN_NUM_DEF,
    parameter int PTN_W          = PTN_W_DEF,
    parameter int FRAMES_PER_PTN = FRAMES_PER_PTN_DEF,
    parameter int DEBOUNCE_CYC   = DEBOUNCE_CYC_DEF
) (
    input  logic                   PCK,
    input  logic                   RST,
    input  logic                   VGA_VSYNC,
    input  logic                   MODE_AUTO,
    input  logic                   BTN_NEXT,
    output logic [PTN_W-1:0]       PTN_SEL,
    output logic                   PTN_CHANGE,
    output logic [FRAME_CNT_W-1:0] FRAME_CNT
);

    generate
        if (PTN_NUM < 2 || PTN_NUM > 16 || (2 ** PTN_W) < PTN_NUM ||
            FRAMES_PER_PTN < 1 || FRAMES_PER_PTN > 1023) begin : g_bad_param
            $error("ptn_sequencer: illegal parameter set");
        end
    endgenerate

    localparam logic [PTN_W-1:0]       C_PTN_LAST   = PTN_W'(PTN_NUM - 1);
    localparam logic [FRAME_CNT_W-1:0] C_FRAME_LAST = FRAME_CNT_W'(FRAMES_PER_PTN - 1);

    logic                   btn_evt;
    logic                   fb;
    logic                   advance;
    seq_state_e             mode_new;

    logic                   vsync_q;
    logic                   mode_s1_q;
    logic                   mode_s2_q;
    seq_state_e             state_q,     state_d;
    logic                   pending_q,   pending_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [PTN_W-1:0]       sel_q,       sel_d;
    logic                   change_q,    change_d;

    ptn_btn_sync #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_btn_sync (
        .PCK      (PCK),
        .RST      (RST),
        .BTN_NEXT (BTN_NEXT),
        .btn_evt  (btn_evt)
    );

    assign fb       = vsync_q & ~VGA_VSYNC;
    assign mode_new = seq_state_e'(mode_s2_q);

    always_comb begin
        state_d     = mode_new;
        pending_d   = pending_q;
        frame_cnt_d = frame_cnt_q;
        advance     = 1'b0;
        // A mode switch wins over a coincident frame boundary: clear and skip.
        if (mode_new != state_q) begin
            frame_cnt_d = '0;
            pending_d   = 1'b0;
        end else if (state_q == S_AUTO) begin
            pending_d = 1'b0;
            if (fb) begin
                if (frame_cnt_q == C_FRAME_LAST) begin
                    frame_cnt_d = '0;
                    advance     = 1'b1;
                end else begin
                    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                end
            end
        end else begin
            frame_cnt_d = '0;
            if (fb && (pending_q || btn_evt)) begin
                advance   = 1'b1;
                pending_d = 1'b0;
            end else if (btn_evt) begin
                pending_d = 1'b1;
            end
        end

        sel_d    = sel_q;
        change_d = advance;
        if (advance) begin
            sel_d = (sel_q == C_PTN_LAST) ? '0 : sel_q + PTN_W'(1);
        end
    end

    always_ff @(posedge PCK or posedge RST) begin
        if (RST) begin
            vsync_q     <= 1'b1;
            mode_s1_q   <= 1'b0;
            mode_s2_q   <= 1'b0;
            state_q     <= S_MANUAL;
            pending_q   <= 1'b0;
            frame_cnt_q <= '0;
            sel_q       <= '0;
            change_q    <= 1'b0;
        end else begin
            vsync_q     <= VGA_VSYNC;
            mode_s1_q   <= MODE_AUTO;
            mode_s2_q   <= mode_s1_q;
            state_q     <= state_d;
            pending_q   <= pending_d;
            frame_cnt_q <= frame_cnt_d;
            sel_q       <= sel_d;
            change_q    <= change_d;
        end
    end

    assign PTN_SEL    = sel_q;
    assign PTN_CHANGE = change_q;
    assign FRAME_CNT  = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ptn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ptn_sequencer
// Purpose  : Self-checking bench for ptn_sequencer against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ptn_sequencer;

    localparam int PTN_NUM = 8;
    localparam int PTN_W   = 4;
    localparam int FPP     = 4;
    localparam int DBC     = 16;

    logic             PCK       = 1'b0;
    logic             RST       = 1'b1;
    logic             VGA_VSYNC = 1'b1;
    logic             MODE_AUTO = 1'b0;
    logic             BTN_NEXT  = 1'b0;
    logic [PTN_W-1:0] PTN_SEL;
    logic             PTN_CHANGE;
    logic [9:0]       FRAME_CNT;

    int n_tests = 0;
    int n_fail  = 0;
    int chg_cnt = 0;
    bit chk_en  = 1'b0;

    always #5 PCK = ~PCK;

    ptn_sequencer #(
        .PTN_NUM        (PTN_NUM),
        .PTN_W          (PTN_W),
        .FRAMES_PER_PTN (FPP),
        .DEBOUNCE_CYC   (DBC)
    ) dut (
        .PCK        (PCK),
        .RST        (RST),
        .VGA_VSYNC  (VGA_VSYNC),
        .MODE_AUTO  (MODE_AUTO),
        .BTN_NEXT   (BTN_NEXT),
        .PTN_SEL    (PTN_SEL),
        .PTN_CHANGE (PTN_CHANGE),
        .FRAME_CNT  (FRAME_CNT)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: pattern index, frame count and pending request,
    // fed by input histories that account for the synchronizer delays.
    int m_sel  = 0;
    int m_cnt  = 0;
    bit m_chg  = 1'b0;
    bit m_pend = 1'b0;
    bit m_auto = 1'b0;
    bit v_last = 1'b1;
    bit b_h [3];
    bit mh  [2];
    bit dlvl   = 1'b0;
    bit dprev  = 1'b0;
    int dcnt   = 0;

    always @(posedge PCK or posedge RST) begin : model
        bit fb, evt, mode, adv;
        if (RST) begin
            m_sel = 0; m_cnt = 0; m_chg = 1'b0; m_pend = 1'b0; m_auto = 1'b0;
            v_last = 1'b1; b_h = '{default: 1'b0}; mh = '{default: 1'b0};
            dlvl = 1'b0; dprev = 1'b0; dcnt = 0;
        end else begin
            fb = v_last && !VGA_VSYNC;
`ifdef PTN_SEQ_DEBOUNCE_EN
            evt   = dlvl && !dprev;
            dprev = dlvl;
            if (b_h[1] != dlvl) begin
                dcnt++;
                if (dcnt == DBC) begin
                    dlvl = b_h[1];
                    dcnt = 0;
                end
            end else begin
                dcnt = 0;
            end
`else
            evt = b_h[1] && !b_h[2];
`endif
            mode  = mh[1];
            adv   = 1'b0;
            m_chg = 1'b0;
            if (mode != m_auto) begin
                m_auto = mode;
                m_cnt  = 0;
                m_pend = 1'b0;
            end else if (m_auto) begin
                if (fb) begin
                    m_cnt++;
                    if (m_cnt == FPP) begin
                        m_cnt = 0;
                        adv   = 1'b1;
                    end
                end
            end else begin
                if (evt) m_pend = 1'b1;
                if (fb && m_pend) begin
                    adv    = 1'b1;
                    m_pend = 1'b0;
                end
            end
            if (adv) begin
                m_sel = (m_sel + 1) % PTN_NUM;
                m_chg = 1'b1;
            end
            mh[1]  = mh[0];  mh[0]  = MODE_AUTO;
            b_h[2] = b_h[1]; b_h[1] = b_h[0]; b_h[0] = BTN_NEXT;
            v_last = VGA_VSYNC;
        end
    end

    always @(negedge PCK) begin
        if (chk_en) begin
            chk("ptn_sel",    int'(PTN_SEL),    m_sel);
            chk("ptn_change", int'(PTN_CHANGE), int'(m_chg));
            chk("frame_cnt",  int'(FRAME_CNT),  m_cnt);
        end
    end

    task automatic cyc(input logic v, input logic b);
        @(negedge PCK);
        #1;
        VGA_VSYNC = v;
        BTN_NEXT  = b;
        if (PTN_CHANGE) chg_cnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b0);
    endtask

    task automatic frame(input int len);
        for (int i = 0; i < len; i++) cyc((i < len - 2) ? 1'b1 : 1'b0, 1'b0);
    endtask

    task automatic press(input int len);
        repeat (len) cyc(1'b1, 1'b1);
        repeat (4) cyc(1'b1, 1'b0);
    endtask

    initial begin : stim
        int   s0;
        int   fc;
        int   flen;
        logic v;
        logic b;

        // Reset and auto-mode wrap
        MODE_AUTO = 1'b1;
        repeat (5) cyc(1'b1, 1'b0);
        RST    = 1'b0;
        chk_en = 1'b1;
        chk("rst_sel",  int'(PTN_SEL),    0);
        chk("rst_chg",  int'(PTN_CHANGE), 0);
        chk("rst_fcnt", int'(FRAME_CNT),  0);
        chg_cnt = 0;
        repeat (40) frame(10);
        idle(3);
        chk("auto_changes", chg_cnt, 10);
        chk("auto_sel", int'(PTN_SEL), 10 % PTN_NUM);
        chk("auto_fcnt_end", int'(FRAME_CNT), 0);

        // Manual stepping, several presses collapse into one advance
        MODE_AUTO = 1'b0;
        idle(6);
        s0 = m_sel;
        chk("manual_fcnt0", int'(FRAME_CNT), 0);
        press(1); press(2); press(1);
        chk("manual_no_fb", int'(PTN_SEL), s0);
        frame(8); idle(3);
        chk("manual_one_adv", int'(PTN_SEL), (s0 + 1) % PTN_NUM);
        press(1); frame(8); idle(3);
        chk("manual_second", int'(PTN_SEL), (s0 + 2) % PTN_NUM);
        repeat (40) cyc(1'b1, 1'b0);
        repeat (40) cyc(1'b0, 1'b0);
        idle(3);
        chk("vsync_stuck", int'(PTN_SEL), (s0 + 2) % PTN_NUM);

        // Button edge coincident with the frame boundary
        s0 = m_sel;
        cyc(1'b1, 1'b1); cyc(1'b1, 1'b1); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
        idle(4);
        chk("simul_adv", int'(PTN_SEL), (s0 + 1) % PTN_NUM);
        // Button just after the boundary waits for the next one
        s0 = m_sel;
        cyc(1'b0, 1'b0); cyc(1'b0, 1'b1); cyc(1'b0, 1'b0);
        idle(4);
        chk("post_fb_hold", int'(PTN_SEL), s0);
        frame(8); idle(3);
        chk("post_fb_next", int'(PTN_SEL), (s0 + 1) % PTN_NUM);

        // Mode switching clears the frame count
        MODE_AUTO = 1'b1;
        idle(5);
        s0 = m_sel;
        frame(10); frame(10); idle(2);
        chk("auto_fcnt2", int'(FRAME_CNT), 2);
        MODE_AUTO = 1'b0;
        idle(5);
        chk("switch_fcnt0", int'(FRAME_CNT), 0);
        chk("switch_no_adv", int'(PTN_SEL), s0);
        MODE_AUTO = 1'b1;
        idle(5);
        repeat (3) frame(10);
        idle(2);
        chk("auto_3fb_hold", int'(PTN_SEL), s0);
        frame(10); idle(2);
        chk("auto_4fb_adv", int'(PTN_SEL), (s0 + 1) % PTN_NUM);

        // Reset mid-operation drops a pending request
        MODE_AUTO = 1'b0;
        idle(5);
        for (int i = 0; i < 16 && m_sel != 5; i++) begin
            press(1); frame(8); idle(2);
        end
        chk("reach5", int'(PTN_SEL), 5);
        press(1);
        RST = 1'b1;
        repeat (20) cyc(1'b1, 1'b0);
        chk("rst_mid_sel", int'(PTN_SEL), 0);
        RST = 1'b0;
        idle(3); frame(8); idle(3);
        chk("rst_no_pending", int'(PTN_SEL), 0);

        // Short glitch and a long press
        s0 = m_sel;
        repeat (10) cyc(1'b1, 1'b1);
        idle(30); frame(8); idle(3);
`ifdef PTN_SEQ_DEBOUNCE_EN
        chk("glitch", int'(PTN_SEL), s0);
`else
        chk("glitch", int'(PTN_SEL), (s0 + 1) % PTN_NUM);
`endif
        s0 = m_sel;
        repeat (20) cyc(1'b1, 1'b1);
        idle(30); frame(8); idle(3);
        chk("long_press", int'(PTN_SEL), (s0 + 1) % PTN_NUM);

        // Randomized traffic: variable frame lengths, button chatter, mode flips
        fc   = 0;
        flen = 12;
        b    = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            v  = (fc < flen - 2) ? 1'b1 : 1'b0;
            fc = fc + 1;
            if (fc == flen) begin
                fc   = 0;
                flen = $urandom_range(6, 30);
            end
            if ($urandom_range(0, 99) < 15) b = ~b;
            if ($urandom_range(0, 999) < 5) MODE_AUTO = ~MODE_AUTO;
            cyc(v, b);
        end
        idle(3);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
